// File: rtl/tlc5957_pkg.sv
// Shared TLC5957 definitions: LAT-count command codes, GS bank geometry and helpers.
package tlc5957_pkg;

  localparam int unsigned GS_WORD_W = 48;
  localparam int unsigned GS_WORDS  = 16;
  localparam int unsigned CMD_W     = 5;
  localparam int unsigned PTR_W     = $clog2(GS_WORDS);

  localparam logic [CMD_W-1:0] WRTGS   = 5'd1;
  localparam logic [CMD_W-1:0] LATGS   = 5'd3;
  localparam logic [CMD_W-1:0] WRTFC   = 5'd5;
  localparam logic [CMD_W-1:0] READFC  = 5'd11;
  localparam logic [CMD_W-1:0] FCWRTEN = 5'd15;

  typedef enum logic [CMD_W-1:0] {
    CmdWrtgs   = WRTGS,
    CmdLatgs   = LATGS,
    CmdWrtfc   = WRTFC,
    CmdReadfc  = READFC,
    CmdFcwrten = FCWRTEN
  } tlc_cmd_e;

  // LAT-high edge counter saturates rather than wrapping into a valid code.
  function automatic logic [CMD_W-1:0] sat_inc(input logic [CMD_W-1:0] v);
    return (v == {CMD_W{1'b1}}) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/tlc5957_receiver_sync_edge.sv
// tlc_sync_edge: 2-FF synchronizer for an asynchronous level with rise/fall strobes.
module tlc_sync_edge (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // ff_q[2] is the previous synchronized value, used only for edge detection.
  logic [2:0] ff_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ff_q <= 3'b000;
    end else begin
      ff_q <= {ff_q[1:0], din};
    end
  end

  assign dout = ff_q[1];
  assign rise = ff_q[1] & ~ff_q[2];
  assign fall = ~ff_q[1] & ff_q[2];

endmodule

// File: rtl/tlc5957_receiver.sv
// TLC5957 serial-protocol receiver model: GS double buffer, FC register, LAT-count decoder.
// Optional READFC readback path is enabled by defining TLC_RECEIVER_READFC_EN.
module tlc5957_receiver
  import tlc5957_pkg::*;
(
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 drv_sclk,
  input  logic                 drv_lat,
  input  logic                 drv_sin,
  output logic                 drv_sout,
  output logic [GS_WORD_W-1:0] fc_reg,
  output logic                 fc_wen,
  output logic                 cmd_valid,
  output logic [CMD_W-1:0]     cmd_code,
  output logic                 cmd_err,
  output logic                 gs_latched,
  input  logic [PTR_W-1:0]     gs_rd_addr,
  output logic [GS_WORD_W-1:0] gs_rd_data
);

  logic sclk_rise;
  logic lat_s, lat_fall;
  logic [1:0] sin_ff_q;
  logic sin_s;

  tlc_sync_edge u_sync_sclk (
    .clk  (clk),
    .nrst (nrst),
    .din  (drv_sclk),
    .dout (),
    .rise (sclk_rise),
    .fall ()
  );

  tlc_sync_edge u_sync_lat (
    .clk  (clk),
    .nrst (nrst),
    .din  (drv_lat),
    .dout (lat_s),
    .rise (),
    .fall (lat_fall)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sin_ff_q <= 2'b00;
    end else begin
      sin_ff_q <= {sin_ff_q[0], drv_sin};
    end
  end
  assign sin_s = sin_ff_q[1];

  logic [GS_WORD_W-1:0] sr_q, sr_d, sr_upd;
  logic [CMD_W-1:0]     lat_cnt_q, lat_cnt_d, lat_cnt_upd;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [GS_WORD_W-1:0] bank1_q [GS_WORDS];
  logic [GS_WORD_W-1:0] bank2_q [GS_WORDS];
  logic                 bank1_wen;
  logic                 copy_q, copy_d;
  logic [GS_WORD_W-1:0] fc_reg_q, fc_reg_d;
  logic                 fc_wen_q, fc_wen_d;
  logic [CMD_W-1:0]     cmd_code_q, cmd_code_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [GS_WORD_W-1:0] gs_rd_data_q;
  logic [1:0]           fill_q, fill_d;
  logic                 armed_q, armed_d;
  logic                 decode;
  logic                 sout_load;

  // Same-cycle SCLK edge and LAT fall: the decoder sees the post-edge values.
  assign sr_upd      = sclk_rise ? {sr_q[GS_WORD_W-2:0], sin_s} : sr_q;
  assign lat_cnt_upd = (sclk_rise && lat_s) ? sat_inc(lat_cnt_q) : lat_cnt_q;

  // Decoding only starts once LAT has been seen low after reset, so a LAT held
  // high through reset release cannot produce a spurious command.
  assign decode = lat_fall && armed_q;

  always_comb begin
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd3) && !lat_s);
  end

  always_comb begin
    sr_d        = sr_upd;
    lat_cnt_d   = lat_fall ? '0 : lat_cnt_upd;
    wr_ptr_d    = wr_ptr_q;
    bank1_wen   = 1'b0;
    copy_d      = 1'b0;
    fc_reg_d    = fc_reg_q;
    fc_wen_d    = fc_wen_q;
    cmd_code_d  = cmd_code_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    sout_load   = 1'b0;
    if (decode) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = lat_cnt_upd;
      case (lat_cnt_upd)
        CmdWrtgs: begin
          bank1_wen = 1'b1;
          wr_ptr_d  = wr_ptr_q + 4'd1;
        end
        CmdLatgs: begin
          bank1_wen = 1'b1;
          wr_ptr_d  = '0;
          copy_d    = 1'b1;
        end
        CmdFcwrten: fc_wen_d = 1'b1;
        CmdWrtfc: begin
          if (fc_wen_q) begin
            fc_reg_d = sr_upd;
            fc_wen_d = 1'b0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CmdReadfc: sout_load = 1'b1;
        default:   cmd_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sr_q        <= '0;
      lat_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      copy_q      <= 1'b0;
      fc_reg_q    <= '0;
      fc_wen_q    <= 1'b0;
      cmd_code_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      lat_cnt_q   <= lat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      copy_q      <= copy_d;
      fc_reg_q    <= fc_reg_d;
      fc_wen_q    <= fc_wen_d;
      cmd_code_q  <= cmd_code_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
    end
  end

  // Copy cycle reads bank1 after the LATGS word landed; a write in the same
  // cycle goes to bank1 only and is not lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < GS_WORDS; i++) begin
        bank1_q[i] <= '0;
        bank2_q[i] <= '0;
      end
      gs_rd_data_q <= '0;
    end else begin
      if (bank1_wen) begin
        bank1_q[wr_ptr_q] <= sr_upd;
      end
      if (copy_q) begin
        for (int i = 0; i < GS_WORDS; i++) begin
          bank2_q[i] <= bank1_q[i];
        end
      end
      gs_rd_data_q <= bank2_q[gs_rd_addr];
    end
  end

`ifdef TLC_RECEIVER_READFC_EN
  logic [GS_WORD_W-1:0] sout_sr_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sout_sr_q <= '0;
    end else if (sout_load) begin
      sout_sr_q <= fc_reg_q;
    end else if (sclk_rise) begin
      sout_sr_q <= {sout_sr_q[GS_WORD_W-2:0], 1'b0};
    end
  end

  assign drv_sout = sout_sr_q[GS_WORD_W-1];
`else
  logic unused_sout_load;
  assign unused_sout_load = sout_load;
  assign drv_sout         = 1'b0;
`endif

  assign fc_reg     = fc_reg_q;
  assign fc_wen     = fc_wen_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_err    = cmd_err_q;
  assign gs_latched = copy_q;
  assign gs_rd_data = gs_rd_data_q;

endmodule

// File: tb/tb_tlc5957_receiver.sv
// Directed bench for tlc5957_receiver: command table plus FC, GS bank and reset sequences.
module tb_tlc5957_receiver;

  logic        clk = 1'b0;
  logic        nrst;
  logic        drv_sclk, drv_lat, drv_sin;
  logic        drv_sout;
  logic [47:0] fc_reg;
  logic        fc_wen;
  logic        cmd_valid;
  logic [4:0]  cmd_code;
  logic        cmd_err;
  logic        gs_latched;
  logic [3:0]  gs_rd_addr;
  logic [47:0] gs_rd_data;

  tlc5957_receiver dut (
    .clk        (clk),
    .nrst       (nrst),
    .drv_sclk   (drv_sclk),
    .drv_lat    (drv_lat),
    .drv_sin    (drv_sin),
    .drv_sout   (drv_sout),
    .fc_reg     (fc_reg),
    .fc_wen     (fc_wen),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_err    (cmd_err),
    .gs_latched (gs_latched),
    .gs_rd_addr (gs_rd_addr),
    .gs_rd_data (gs_rd_data)
  );

  always #5 clk = ~clk;

  int n_valid = 0;
  int n_err   = 0;
  int n_gsl   = 0;

  always @(posedge clk) begin
    if (cmd_valid)  n_valid <= n_valid + 1;
    if (cmd_err)    n_err   <= n_err + 1;
    if (gs_latched) n_gsl   <= n_gsl + 1;
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic sclk_edge(input logic sin, input logic lat);
    drv_sin  = sin;
    drv_lat  = lat;
    #40 drv_sclk = 1'b1;
    #40 drv_sclk = 1'b0;
  endtask

  // Shift nbits MSB-first with LAT high on the last lat_edges edges, then drop LAT.
  task automatic frame(input logic [47:0] data, input int nbits, input int lat_edges,
                       output int dv, output int de, output int dg);
    int v0, e0, g0;
    v0 = n_valid; e0 = n_err; g0 = n_gsl;
    for (int i = 0; i < nbits; i++) begin
      sclk_edge(data[nbits-1-i], (i >= nbits - lat_edges));
    end
    drv_lat = 1'b0;
    drv_sin = 1'b0;
    #120;
    dv = n_valid - v0; de = n_err - e0; dg = n_gsl - g0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #40 nrst = 1'b1;
    #100;
  endtask

  typedef struct {
    int          lat_edges;
    logic [47:0] data;
    int          exp_err;
    logic [4:0]  exp_code;
  } vec_t;

  vec_t vecs[5];
  int   dv, de, dg;

  initial begin
    vecs[0] = '{lat_edges: 7,  data: 48'h0000_0000_0001, exp_err: 1, exp_code: 5'd7};
    vecs[1] = '{lat_edges: 2,  data: 48'hFFFF_0000_FFFF, exp_err: 1, exp_code: 5'd2};
    vecs[2] = '{lat_edges: 40, data: 48'h1234_5678_9ABC, exp_err: 1, exp_code: 5'd31};
    vecs[3] = '{lat_edges: 31, data: 48'hAAAA_AAAA_AAAA, exp_err: 1, exp_code: 5'd31};
    vecs[4] = '{lat_edges: 11, data: 48'h0F0F_0F0F_0F0F, exp_err: 0, exp_code: 5'd11};

    // Reset with LAT held high through release.
    nrst = 1'b0; drv_sclk = 1'b0; drv_sin = 1'b0; drv_lat = 1'b1; gs_rd_addr = 4'd0;
    #95;
    check("rst_fc_reg", fc_reg, 48'h0);
    check("rst_fc_wen", {47'h0, fc_wen}, 48'h0);
    check("rst_cmd_code", {43'h0, cmd_code}, 48'h0);
    check("rst_drv_sout", {47'h0, drv_sout}, 48'h0);
    check("rst_gs_rd_data", gs_rd_data, 48'h0);
    check("rst_pulses", {45'h0, cmd_valid, cmd_err, gs_latched}, 48'h0);
    #5 nrst = 1'b1;
    #200 drv_lat = 1'b0;
    #200;
    check("lat_thru_rst_valid", 48'(n_valid), 48'd0);
    check("lat_thru_rst_err", 48'(n_err), 48'd0);

    // Command table.
    for (int i = 0; i < 5; i++) begin
      frame(vecs[i].data, 48, vecs[i].lat_edges, dv, de, dg);
      check($sformatf("vec%0d_valid", i), 48'(dv), 48'd1);
      check($sformatf("vec%0d_err", i), 48'(de), 48'(vecs[i].exp_err));
      check($sformatf("vec%0d_code", i), {43'h0, cmd_code}, {43'h0, vecs[i].exp_code});
    end
    check("table_fc_untouched", fc_reg, 48'h0);

    // FCWRTEN then WRTFC.
    frame(48'hA5A5_0000_FFFF, 48, 15, dv, de, dg);
    check("fcwrten_wen", {47'h0, fc_wen}, 48'h1);
    check("fcwrten_err", 48'(de), 48'd0);
    frame(48'h0000_1234_5678, 48, 5, dv, de, dg);
    check("wrtfc_reg", fc_reg, 48'h0000_1234_5678);
    check("wrtfc_wen", {47'h0, fc_wen}, 48'h0);

    // WRTFC without arming.
    frame(48'hDEAD_BEEF_CAFE, 48, 5, dv, de, dg);
    check("wrtfc_noarm_err", 48'(de), 48'd1);
    check("wrtfc_noarm_reg", fc_reg, 48'h0000_1234_5678);

`ifdef TLC_RECEIVER_READFC_EN
    frame(48'h0, 48, 15, dv, de, dg);
    frame(48'h8000_0000_0001, 48, 5, dv, de, dg);
    check("readfc_src", fc_reg, 48'h8000_0000_0001);
    frame(48'h0, 48, 11, dv, de, dg);
    check("readfc_err", 48'(de), 48'd0);
    check("readfc_sout0", {47'h0, drv_sout}, 48'h1);
    for (int e = 1; e <= 47; e++) begin
      sclk_edge(1'b1, 1'b0);
      if (e == 1 || e == 23 || e == 46) check($sformatf("readfc_sout%0d", e), {47'h0, drv_sout}, 48'h0);
      if (e == 47) check("readfc_sout47", {47'h0, drv_sout}, 48'h1);
    end
`else
    frame(48'hFFFF_FFFF_FFFF, 48, 11, dv, de, dg);
    check("readfc_off_err", 48'(de), 48'd0);
    check("readfc_off_valid", 48'(dv), 48'd1);
    sclk_edge(1'b1, 1'b0);
    check("readfc_off_sout", {47'h0, drv_sout}, 48'h0);
`endif

    // GS double buffer: 15 WRTGS + LATGS.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      frame(48'(k * 'h111), 48, 1, dv, de, dg);
    end
    check("gs_pre_latch", 48'(n_gsl), 48'd0);
    frame(48'hFFF, 48, 3, dv, de, dg);
    check("gs_latched_once", 48'(dg), 48'd1);
    gs_rd_addr = 4'd3;
    #30 check("gs_addr3", gs_rd_data, 48'h333);
    gs_rd_addr = 4'd15;
    #30 check("gs_addr15", gs_rd_data, 48'hFFF);
    gs_rd_addr = 4'd10;
    #30 check("gs_addr10", gs_rd_data, 48'hAAA);
    check("gs_wr_ptr", {44'h0, dut.wr_ptr_q}, 48'h0);

    // Reset mid-frame, then a clean WRTGS and LATGS.
    for (int i = 0; i < 20; i++) sclk_edge(i[0], 1'b0);
    do_reset();
    gs_rd_addr = 4'd0;
    #30 check("midrst_bank2_clear", gs_rd_data, 48'h0);
    frame(48'h0123_4567_89AB, 48, 1, dv, de, dg);
    frame(48'hFEDC_BA98_7654, 48, 3, dv, de, dg);
    gs_rd_addr = 4'd0;
    #30 check("midrst_word0", gs_rd_data, 48'h0123_4567_89AB);
    gs_rd_addr = 4'd1;
    #30 check("midrst_word1", gs_rd_data, 48'hFEDC_BA98_7654);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
